// File: rtl/conv_pkg.sv
// ============================================================================
// conv_pkg : shared types and frame-size defaults for the 3x3 conv front end
// Rev 1.0
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int CONV_IMG_W = 32;
    localparam int CONV_IMG_H = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/conv_scan_ctrl.sv
// ============================================================================
// conv_scan_ctrl : raster-scan sequencer for one frame of the 3x3 conv path
// Rev 1.0
// ============================================================================
`default_nettype none

module conv_scan_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W = CONV_IMG_W,
    parameter int IMG_H = CONV_IMG_H,
    parameter int COL_W = $clog2(IMG_W),
    parameter int ROW_W = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             win_ready,
    output logic             lb_wr_en,
    output logic [COL_W-1:0] lb_addr,
    output logic             buf_valid,
    output logic             in_row2_cond,
    output logic             busy,
    output logic             frame_done
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    scan_state_e      state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             buf_valid_q, buf_valid_d;
    logic             in_row2_cond_q, in_row2_cond_d;

    logic accept;
    logic col_last;
    logic row_last;

    always_comb begin
        pix_ready = win_ready && ((state_q == FILL) || (state_q == RUN));
        accept    = pix_valid && pix_ready;
        col_last  = (col_q == COL_LAST);
        row_last  = (row_q == ROW_LAST);

        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        buf_valid_d    = accept;
        in_row2_cond_d = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            FILL: begin
                if (accept && (row_q == ROW_W'(1)) && col_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && row_last && col_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Counters move only on accept, which cannot occur in IDLE, so this
        // never collides with the clear on start above.
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q        <= IDLE;
            col_q          <= '0;
            row_q          <= '0;
            buf_valid_q    <= 1'b0;
            in_row2_cond_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            buf_valid_q    <= buf_valid_d;
            in_row2_cond_q <= in_row2_cond_d;
        end
    end

    // Write and 3-row read share the live column address in the accept cycle.
    assign lb_wr_en     = accept;
    assign lb_addr      = col_q;
    assign buf_valid    = buf_valid_q;
    assign in_row2_cond = in_row2_cond_q;
    assign busy         = (state_q == FILL) || (state_q == RUN);
    assign frame_done   = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_conv_scan_ctrl.sv
// ============================================================================
// tb_conv_scan_ctrl : scoreboard bench for conv_scan_ctrl at a 4x4 frame
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_conv_scan_ctrl;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       start = 1'b0;
    logic       pix_valid = 1'b0;
    logic       win_ready = 1'b0;
    logic       pix_ready;
    logic       lb_wr_en;
    logic [1:0] lb_addr;
    logic       buf_valid;
    logic       in_row2_cond;
    logic       busy;
    logic       frame_done;

    conv_scan_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .start        (start),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .win_ready    (win_ready),
        .lb_wr_en     (lb_wr_en),
        .lb_addr      (lb_addr),
        .buf_valid    (buf_valid),
        .in_row2_cond (in_row2_cond),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: linear pixel index within the frame plus phase flags.
    bit m_busy = 0;
    bit m_done = 0;
    int m_idx  = 0;

    bit chk_en = 0;
    bit e_ready, e_busy, e_done, e_acc, e_bv, e_addr_chk;
    bit prev_acc = 0;
    int e_addr;

    bit win_q[$];
    int win_cnt   = 0;
    int frame_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pix_ready", int'(pix_ready), int'(e_ready));
            chk("busy", int'(busy), int'(e_busy));
            chk("frame_done", int'(frame_done), int'(e_done));
            chk("lb_wr_en", int'(lb_wr_en), int'(e_acc));
            if (e_addr_chk) chk("lb_addr", int'(lb_addr), e_addr);
            chk("buf_valid", int'(buf_valid), int'(e_bv));
            if (buf_valid) begin
                if (win_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL win_queue: buf_valid got 1 expected no pending window at %0t", $time);
                end else begin
                    chk("in_row2_cond", int'(in_row2_cond), int'(win_q.pop_front()));
                end
                if (in_row2_cond) win_cnt++;
            end else begin
                chk("in_row2_cond_idle", int'(in_row2_cond), 0);
            end
            if (frame_done) frame_cnt++;
        end
    end

    // One clock of stimulus, entered and left at posedge+1.
    task automatic step(input bit v, input bit wr, input bit st);
        bit acc;
        pix_valid  = v;
        win_ready  = wr;
        start      = st;
        e_busy     = m_busy;
        e_done     = m_done;
        e_ready    = m_busy && wr;
        acc        = v && e_ready;
        e_acc      = acc;
        e_addr     = m_idx % W;
        e_addr_chk = m_busy;
        e_bv       = prev_acc;
        prev_acc   = acc;
        if (acc) win_q.push_back(((m_idx / W) >= 2) && ((m_idx % W) >= 2));
        chk_en = 1;
        @(posedge clk);
        if (m_done) begin
            m_done = 0;
        end else if (!m_busy && st) begin
            m_busy = 1;
            m_idx  = 0;
        end else if (acc) begin
            if (m_idx == NPIX - 1) begin
                m_busy = 0;
                m_done = 1;
            end else begin
                m_idx++;
            end
        end
        #1;
    endtask

    task automatic run_to_done();
        int guard = 0;
        while (m_busy && guard < 4 * NPIX) begin
            step(1, 1, 0);
            guard++;
        end
        if (m_busy) begin
            n_vec++;
            n_fail++;
            $display("FAIL run_bound: got %0d steps expected fewer than %0d", guard, 4 * NPIX);
        end
    endtask

    task automatic check_frame(input int frames);
        chk("valid_windows", win_cnt, (W - 2) * (H - 2));
        chk("frame_count", frame_cnt, frames);
        win_cnt = 0;
    endtask

    task automatic check_all_low(input string tag);
        chk({tag, "_pix_ready"}, int'(pix_ready), 0);
        chk({tag, "_lb_wr_en"}, int'(lb_wr_en), 0);
        chk({tag, "_lb_addr"}, int'(lb_addr), 0);
        chk({tag, "_buf_valid"}, int'(buf_valid), 0);
        chk({tag, "_in_row2_cond"}, int'(in_row2_cond), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    initial begin
        // Reset held with a source offering pixels.
        rstb      = 1'b0;
        pix_valid = 1'b1;
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_low("reset");
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;

        // Frame 1: uninterrupted stream.
        step(0, 1, 1);
        run_to_done();
        step(0, 1, 0);
        check_frame(1);

        // Frame 2: stall at (2,1), start in RUN, source bubble, start in DONE.
        step(0, 1, 1);
        repeat (9) step(1, 1, 0);
        repeat (3) step(1, 0, 0);
        step(1, 1, 1);
        repeat (2) step(1, 1, 0);
        repeat (2) step(0, 1, 0);
        run_to_done();
        step(0, 1, 1);
        check_frame(2);

        // Frame 3: start in the IDLE cycle after DONE, then reset at (1,2).
        step(0, 1, 1);
        repeat (6) step(1, 1, 0);
        chk_en    = 0;
        pix_valid = 1'b1;
        win_ready = 1'b1;
        rstb      = 1'b0;
        #1;
        check_all_low("midreset");
        m_busy   = 0;
        m_done   = 0;
        m_idx    = 0;
        prev_acc = 0;
        win_q.delete();
        win_cnt  = 0;
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;

        // Frame 4: fresh frame after the aborted one.
        step(0, 1, 1);
        run_to_done();
        step(0, 1, 0);
        check_frame(3);
        step(0, 1, 0);
        chk("win_queue_empty", win_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
